// File: rtl/mux2_arb.sv
// mux2_arb: merges two packet streams through per-input data/status FIFOs with a round-robin
// packet arbiter. Define MUX2_ARB_PKTCNT_EN to add forwarded/dropped packet counters.
module mux2_arb #(
  parameter int DFIFO_AW = 8,
  parameter int PFIFO_AW = 4,
  parameter int ALF_TH   = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_data_wr,
  input  logic [133:0] in0_data,
  input  logic         in0_data_valid,
  input  logic         in0_data_valid_wr,
  output logic         in0_data_alf,
  input  logic         in1_data_wr,
  input  logic [133:0] in1_data,
  input  logic         in1_data_valid,
  input  logic         in1_data_valid_wr,
  output logic         in1_data_alf,
  output logic         out_data_wr,
  output logic [133:0] out_data,
  output logic         out_data_valid,
  output logic         out_data_valid_wr,
  input  logic         out_data_alf,
  output logic [1:0]   ovf_err
`ifdef MUX2_ARB_PKTCNT_EN
  ,
  output logic [31:0]  pkt_cnt0,
  output logic [31:0]  pkt_cnt1,
  output logic [31:0]  drop_cnt
`endif
);

  localparam int DATA_W = 134;
  localparam int DDEPTH = 1 << DFIFO_AW;
  localparam int PDEPTH = 1 << PFIFO_AW;
  localparam int DCW    = DFIFO_AW + 1;
  localparam int PCW    = PFIFO_AW + 1;
  localparam logic [DCW-1:0] DFULL = DCW'(DDEPTH);
  localparam logic [DCW-1:0] DALF  = DCW'(ALF_TH);
  localparam logic [PCW-1:0] PFULL = PCW'(PDEPTH);
  localparam logic [PCW-1:0] PALF  = PCW'(PDEPTH - 2);

  typedef enum logic [1:0] {IDLE, SEND, DROP} state_e;

  logic [DATA_W-1:0] dmem0 [DDEPTH];
  logic [DATA_W-1:0] dmem1 [DDEPTH];
  logic [PDEPTH-1:0] pmem0;
  logic [PDEPTH-1:0] pmem1;

  logic [1:0][DFIFO_AW-1:0] dwp_q, drp_q;
  logic [1:0][PFIFO_AW-1:0] pwp_q, prp_q;
  logic [1:0][DCW-1:0]      dcnt_q;
  logic [1:0][PCW-1:0]      pcnt_q;
  logic [1:0] dwr, pwr, dwr_ok, pwr_ok, dpop, ppop, dne, pne, phead;
  logic [1:0] ovf_q, alf_q;

  state_e            state_q, state_d;
  logic              sel_q, sel_d, lg_q, lg_d, gnt, tail_rd;
  logic [DATA_W-1:0] rword;
  logic              owr_q, owr_d, ov_q, ov_d, ovwr_q, ovwr_d;
  logic [DATA_W-1:0] odata_q, odata_d;

  assign dwr   = {in1_data_wr, in0_data_wr};
  assign pwr   = {in1_data_valid_wr, in0_data_valid_wr};
  assign phead = {pmem1[prp_q[1]], pmem0[prp_q[0]]};
  assign rword = sel_q ? dmem1[drp_q[1]] : dmem0[drp_q[0]];
  assign tail_rd = (rword[133:132] == 2'b10);
  // Round-robin: with both inputs waiting, the one not granted last wins.
  assign gnt = (pne[0] && pne[1]) ? ~lg_q : pne[1];

  always_comb begin
    dwr_ok = '0;
    pwr_ok = '0;
    dne    = '0;
    pne    = '0;
    for (int n = 0; n < 2; n++) begin
      dwr_ok[n] = dwr[n] && (dcnt_q[n] != DFULL);
      pwr_ok[n] = pwr[n] && (pcnt_q[n] != PFULL);
      dne[n]    = (dcnt_q[n] != '0);
      pne[n]    = (pcnt_q[n] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (dwr_ok[0]) dmem0[dwp_q[0]] <= in0_data;
    if (dwr_ok[1]) dmem1[dwp_q[1]] <= in1_data;
    if (pwr_ok[0]) pmem0[pwp_q[0]] <= in0_data_valid;
    if (pwr_ok[1]) pmem1[pwp_q[1]] <= in1_data_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwp_q  <= '0;
      drp_q  <= '0;
      pwp_q  <= '0;
      prp_q  <= '0;
      dcnt_q <= '0;
      pcnt_q <= '0;
      ovf_q  <= '0;
      alf_q  <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (dwr_ok[n]) dwp_q[n] <= dwp_q[n] + 1'b1;
        if (dpop[n])   drp_q[n] <= drp_q[n] + 1'b1;
        if (pwr_ok[n]) pwp_q[n] <= pwp_q[n] + 1'b1;
        if (ppop[n])   prp_q[n] <= prp_q[n] + 1'b1;
        dcnt_q[n] <= dcnt_q[n] + DCW'(dwr_ok[n]) - DCW'(dpop[n]);
        pcnt_q[n] <= pcnt_q[n] + PCW'(pwr_ok[n]) - PCW'(ppop[n]);
        if ((dwr[n] && !dwr_ok[n]) || (pwr[n] && !pwr_ok[n])) ovf_q[n] <= 1'b1;
        alf_q[n] <= (dcnt_q[n] >= DALF) || (pcnt_q[n] >= PALF);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      lg_q    <= 1'b1;
      owr_q   <= 1'b0;
      ov_q    <= 1'b0;
      ovwr_q  <= 1'b0;
      odata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lg_q    <= lg_d;
      owr_q   <= owr_d;
      ov_q    <= ov_d;
      ovwr_q  <= ovwr_d;
      odata_q <= odata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lg_d    = lg_q;
    dpop    = '0;
    ppop    = '0;
    owr_d   = 1'b0;
    ov_d    = 1'b0;
    ovwr_d  = 1'b0;
    odata_d = '0;
    unique case (state_q)
      IDLE: begin
        // Bad packets are dropped even under downstream back-pressure.
        if (pne != 2'b00) begin
          if (!phead[gnt]) begin
            ppop[gnt] = 1'b1;
            sel_d     = gnt;
            state_d   = DROP;
          end else if (!out_data_alf) begin
            ppop[gnt] = 1'b1;
            sel_d     = gnt;
            state_d   = SEND;
          end
        end
      end
      SEND: begin
        if (dne[sel_q]) begin
          dpop[sel_q] = 1'b1;
          owr_d       = 1'b1;
          odata_d     = rword;
          if (tail_rd) begin
            ov_d    = 1'b1;
            ovwr_d  = 1'b1;
            lg_d    = sel_q;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (dne[sel_q]) begin
          dpop[sel_q] = 1'b1;
          if (tail_rd) begin
            lg_d    = sel_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data_wr       = owr_q;
  assign out_data          = odata_q;
  assign out_data_valid    = ov_q;
  assign out_data_valid_wr = ovwr_q;
  assign in0_data_alf      = alf_q[0];
  assign in1_data_alf      = alf_q[1];
  assign ovf_err           = ovf_q;

`ifdef MUX2_ARB_PKTCNT_EN
  logic [31:0] pkt0_q, pkt1_q, drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt0_q <= '0;
      pkt1_q <= '0;
      drop_q <= '0;
    end else begin
      if (ovwr_d && !sel_q) pkt0_q <= pkt0_q + 32'd1;
      if (ovwr_d && sel_q)  pkt1_q <= pkt1_q + 32'd1;
      if ((state_q == DROP) && dne[sel_q] && tail_rd) drop_q <= drop_q + 32'd1;
    end
  end

  assign pkt_cnt0 = pkt0_q;
  assign pkt_cnt1 = pkt1_q;
  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_mux2_arb.sv
// Testbench for mux2_arb: table of single-packet vectors plus hand-written sequences,
// output words checked against a scoreboard queue filled as stimulus is driven.
module tb_mux2_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         in0_data_wr, in0_data_valid, in0_data_valid_wr, in0_data_alf;
  logic [133:0] in0_data;
  logic         in1_data_wr, in1_data_valid, in1_data_valid_wr, in1_data_alf;
  logic [133:0] in1_data;
  logic         out_data_wr, out_data_valid, out_data_valid_wr, out_data_alf;
  logic [133:0] out_data;
  logic [1:0]   ovf_err;
`ifdef MUX2_ARB_PKTCNT_EN
  logic [31:0]  pkt_cnt0, pkt_cnt1, drop_cnt;
`endif

  always #5 clk = ~clk;

  mux2_arb dut (
    .clk(clk), .rst(rst),
    .in0_data_wr(in0_data_wr), .in0_data(in0_data), .in0_data_valid(in0_data_valid),
    .in0_data_valid_wr(in0_data_valid_wr), .in0_data_alf(in0_data_alf),
    .in1_data_wr(in1_data_wr), .in1_data(in1_data), .in1_data_valid(in1_data_valid),
    .in1_data_valid_wr(in1_data_valid_wr), .in1_data_alf(in1_data_alf),
    .out_data_wr(out_data_wr), .out_data(out_data), .out_data_valid(out_data_valid),
    .out_data_valid_wr(out_data_valid_wr), .out_data_alf(out_data_alf),
    .ovf_err(ovf_err)
`ifdef MUX2_ARB_PKTCNT_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_cnt(drop_cnt)
`endif
  );

  typedef struct {
    logic [133:0] data;
    logic         tail;
  } exp_t;

  typedef struct {
    int port;
    int len;
    bit good;
    bit fwd;
  } pkt_vec_t;

  exp_t exp_q[$];
  int   nvec = 0, nmis = 0, cyc = 0, owords = 0;
  int   last_head = -1, last_tail = -1, last_vw = -1;
  bit   gap_chk = 1'b0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (out_data_wr === 1'b1) begin
      owords++;
      if (out_data[133:132] == 2'b01) begin
        if (gap_chk && last_tail >= 0) chk("b2b_gap", 136'(cyc - last_tail), 136'd2);
        last_head = cyc;
      end
      if (out_data[133:132] == 2'b10) last_tail = cyc;
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_word: got %0h, expected no output", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 136'(out_data), 136'(e.data));
        chk("out_valid_flags", 136'({out_data_valid, out_data_valid_wr}), 136'({e.tail, e.tail}));
      end
    end else begin
      chk("idle_out", {out_data_valid_wr, out_data_valid, out_data}, 136'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0 after %0d cycles", exp_q.size(), max);
      exp_q.delete();
    end
  endtask

  function automatic logic [133:0] mkword(input int i, input int len);
    logic [133:0] w;
    w[133:132] = (i == 0) ? 2'b01 : ((i == len - 1) ? 2'b10 : 2'b11);
    w[131:116] = 16'(i);
    w[115:0]   = {$urandom(), $urandom(), $urandom(), 20'($urandom())};
    return w;
  endfunction

  task automatic drive_pkts(input int len0, input bit good0, input bit exp0,
                            input int len1, input bit good1, input bit exp1);
    logic [133:0] w0[$], w1[$];
    exp_t e;
    int   n;
    for (int i = 0; i < len0; i++) w0.push_back(mkword(i, len0));
    for (int i = 0; i < len1; i++) w1.push_back(mkword(i, len1));
    if (exp0) for (int i = 0; i < len0; i++) begin
      e.data = w0[i]; e.tail = (i == len0 - 1); exp_q.push_back(e);
    end
    if (exp1) for (int i = 0; i < len1; i++) begin
      e.data = w1[i]; e.tail = (i == len1 - 1); exp_q.push_back(e);
    end
    n = (len0 > len1) ? len0 : len1;
    for (int i = 0; i < n; i++) begin
      in0_data_wr = 1'b0; in0_data = '0; in0_data_valid_wr = 1'b0; in0_data_valid = 1'b0;
      in1_data_wr = 1'b0; in1_data = '0; in1_data_valid_wr = 1'b0; in1_data_valid = 1'b0;
      if (i < len0) begin
        in0_data_wr = 1'b1; in0_data = w0[i];
        in0_data_valid_wr = (i == len0 - 1); in0_data_valid = (i == len0 - 1) && good0;
      end
      if (i < len1) begin
        in1_data_wr = 1'b1; in1_data = w1[i];
        in1_data_valid_wr = (i == len1 - 1); in1_data_valid = (i == len1 - 1) && good1;
      end
      cycle();
      if (i == n - 1) last_vw = cyc;
    end
    in0_data_wr = 1'b0; in0_data = '0; in0_data_valid_wr = 1'b0; in0_data_valid = 1'b0;
    in1_data_wr = 1'b0; in1_data = '0; in1_data_valid_wr = 1'b0; in1_data_valid = 1'b0;
  endtask

  task automatic raw_write0(input int n);
    for (int i = 0; i < n; i++) begin
      in0_data_wr = 1'b1;
      in0_data    = mkword(1, 3);
      cycle();
    end
    in0_data_wr = 1'b0;
    in0_data    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_alf", 136'({in1_data_alf, in0_data_alf}), 136'd0);
    chk("rst_ovf", 136'(ovf_err), 136'd0);
    chk("rst_out", 136'({out_data_wr, out_data_valid, out_data_valid_wr}), 136'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    pkt_vec_t tbl[8];
    int exp_p0 = 1, exp_p1 = 0, exp_drop = 0;
    int vw, a, base, n;

    tbl[0] = '{0, 2, 1'b1, 1'b1};
    tbl[1] = '{1, 3, 1'b1, 1'b1};
    tbl[2] = '{0, 5, 1'b1, 1'b1};
    tbl[3] = '{1, 3, 1'b0, 1'b0};
    tbl[4] = '{1, 4, 1'b1, 1'b1};
    tbl[5] = '{0, 3, 1'b0, 1'b0};
    tbl[6] = '{0, 4, 1'b1, 1'b1};
    tbl[7] = '{1, 2, 1'b1, 1'b1};

    rst = 1'b1; out_data_alf = 1'b0;
    in0_data_wr = 1'b0; in0_data = '0; in0_data_valid_wr = 1'b0; in0_data_valid = 1'b0;
    in1_data_wr = 1'b0; in1_data = '0; in1_data_valid_wr = 1'b0; in1_data_valid = 1'b0;
    do_reset();

    // single good packet: head two cycles after the status entry lands
    drive_pkts(4, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    vw = last_vw;
    drain(30);
    chk("head_latency", 136'(last_head - vw), 136'd2);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].port == 0) drive_pkts(tbl[i].len, tbl[i].good, tbl[i].fwd, 0, 1'b0, 1'b0);
      else                  drive_pkts(0, 1'b0, 1'b0, tbl[i].len, tbl[i].good, tbl[i].fwd);
      drain(40);
      idle(8);
      if (!tbl[i].fwd)           exp_drop++;
      else if (tbl[i].port == 0) exp_p0++;
      else                       exp_p1++;
    end

    // bad packet immediately followed by a good one on in1
    drive_pkts(0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    drive_pkts(0, 1'b0, 1'b0, 4, 1'b1, 1'b1);
    drain(40);
    idle(4);
    exp_drop++;
    exp_p1++;
`ifdef MUX2_ARB_PKTCNT_EN
    chk("pkt_cnt0", 136'(pkt_cnt0), 136'(exp_p0));
    chk("pkt_cnt1", 136'(pkt_cnt1), 136'(exp_p1));
    chk("drop_cnt", 136'(drop_cnt), 136'(exp_drop));
`endif

    // both inputs loaded together: in0, in1, in0, in1 with one idle cycle between packets
    do_reset();
    last_tail = -1;
    gap_chk   = 1'b1;
    drive_pkts(4, 1'b1, 1'b1, 4, 1'b1, 1'b1);
    drive_pkts(3, 1'b1, 1'b1, 3, 1'b1, 1'b1);
    drain(60);
    gap_chk = 1'b0;

    // downstream back-pressure holds a good packet
    do_reset();
    out_data_alf = 1'b1;
    drive_pkts(4, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    base = owords;
    idle(10);
    chk("alf_hold", 136'(owords - base), 136'd0);
    a = cyc;
    out_data_alf = 1'b0;
    drain(30);
    chk("alf_release_latency", 136'(last_head - a), 136'd2);

    // data FIFO almost-full threshold and overflow
    do_reset();
    out_data_alf = 1'b1;
    raw_write0(199);
    idle(1);
    chk("alf_199", 136'(in0_data_alf), 136'd0);
    raw_write0(1);
    idle(1);
    chk("alf_200", 136'(in0_data_alf), 136'd1);
    chk("alf_in1_quiet", 136'(in1_data_alf), 136'd0);
    raw_write0(56);
    chk("ovf_256", 136'(ovf_err), 136'd0);
    raw_write0(1);
    chk("ovf_257", 136'(ovf_err), 136'd1);

    // status FIFO almost-full at depth-2 entries
    do_reset();
    out_data_alf = 1'b1;
    for (int i = 0; i < 13; i++) drive_pkts(0, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    idle(1);
    chk("palf_13", 136'(in1_data_alf), 136'd0);
    drive_pkts(0, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    idle(1);
    chk("palf_14", 136'(in1_data_alf), 136'd1);
    out_data_alf = 1'b0;

    // reset in the middle of a 6-word packet
    do_reset();
    base = owords;
    drive_pkts(6, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    n = 0;
    while ((owords - base) < 3 && n < 30) begin
      cycle();
      n++;
    end
    chk("mid_words_seen", 136'(owords - base), 136'd3);
    do_reset();
    idle(6);
    drive_pkts(5, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    vw = last_vw;
    drain(30);
    chk("post_rst_latency", 136'(last_head - vw), 136'd2);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
